ifetch: RTL
===========

# ifetch

Instruction fetch unit: the initiator side of the core's instruction-memory port. It generates sequential word addresses starting from a reset vector and reads the single-port instruction SRAM, which returns data one cycle after the address. Returned words, tagged with their PC, go into a small skid FIFO feeding decode over a valid/ready handshake. It sits between the instruction memory and the decode stage, and it handles PC redirects from execute (branches and jumps).

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.
- `FIFO_DEPTH`, default 2: output FIFO entries; minimum 2.
- `i_clk` input, 1: clock.
- `i_rst_n` input, 1: reset, asynchronous, active-low.
- `o_imem_addr` output, 32: fetch byte address, always word-aligned.
- `i_imem_rd_data` input, 32: SRAM read data for the address presented in the previous cycle.
- `o_imem_wr_data` output, 32: constant 32'h0.
- `o_imem_size` output, 4: constant 4'hF (active-low byte enables, no byte written).
- `o_imem_write` output, 1: constant 0.
- `o_imem_read` output, 1: constant 1 (global write enable deasserted, so the SRAM reads every cycle).
- `i_redirect` input, 1: single-cycle request to restart fetch at `i_redirect_pc`.
- `i_redirect_pc` input, 32: target address; bits [1:0] are ignored and forced to 0.
- `o_valid` output, 1: `o_instr` and `o_pc` hold a valid instruction.
- `i_ready` input, 1: decode accepts the instruction.
- `o_instr` output, 32: instruction word.
- `o_pc` output, 32: address of `o_instr`.

## Operation
- State: `fetch_pc`; `inflight` (1 bit, an issued read whose data arrives next cycle); `inflight_pc`; `kill` (1 bit, discard the in-flight response); FIFO of {pc, instr}.
- `o_imem_addr` = `fetch_pc` in every cycle. The SRAM reads every cycle. Data is captured only for issued addresses.
- `pop` = `o_valid & i_ready & ~i_redirect`.
- Issue condition: `issue` = `~i_redirect & (count + inflight - pop < FIFO_DEPTH)`, where `count` is the FIFO occupancy.
- On issue:
  - `inflight` <= 1.
  - `inflight_pc` <= `fetch_pc`.
  - `fetch_pc` <= `fetch_pc` + 4. The add is 32-bit and wraps from 32'hFFFF_FFFC to 0.
- Otherwise `inflight` <= 0.
- Response: when `inflight & ~kill`, push {`inflight_pc`, `i_imem_rd_data`} into the FIFO.
  - Overflow is impossible by the credit rule above.
  - Push and pop may occur in the same cycle.
- Redirect (takes priority over everything):
  - FIFO is flushed; any concurrent pop is void.
  - `fetch_pc` <= {`i_redirect_pc`[31:2], 2'b00}.
  - `kill` <= 1, which discards the response of any read issued in the redirect cycle.
  - No issue happens in the redirect cycle.
  - Back-to-back redirects: the last one wins.
- `kill` clears in the cycle after it is set.
- Reset values:
  - `fetch_pc` = `RESET_PC`; `o_imem_addr` = `RESET_PC`.
  - `inflight` = 0, `kill` = 0, FIFO empty.
  - `o_valid` = 0; `o_instr` = 0; `o_pc` = 0.
- Reset asserted mid-operation: all of the above apply immediately (asynchronous). The pending SRAM response is ignored.
- The handshake follows valid/ready rules:
  - While `o_valid`=1 and `i_ready`=0, `o_instr` and `o_pc` are held stable.
  - `o_valid` never drops without a pop, redirect, or reset.

## Timing
- Issue in cycle N; data captured at the end of N+1; `o_valid` in N+2. Latency is 2 cycles.
- Reset released before cycle 0: RESET_PC is issued in cycle 0; `o_valid` with `o_pc`=RESET_PC in cycle 2.
- With `i_ready` held high, throughput is 1 instruction/cycle from cycle 2 onward, with consecutive PCs.
- Redirect in cycle R: target issued in R+1; `o_valid` with `o_pc` = target in R+3. No stale instruction appears from R+1 onward.
- With `i_ready`=0, issue stops once `count + inflight` = `FIFO_DEPTH`.
- When `i_ready` rises, throughput resumes with no lost or duplicated PCs.

## Structure
- Package `ifetch_pkg`:
  - `fetch_entry_t` struct {pc[31:0], instr[31:0]}.
  - Constants `IMEM_WEN_NONE` = 4'hF and `IMEM_READ` = 1'b1.
- Sub-module `ifetch_fifo`:
  - Parameterised `FIFO_DEPTH`, element type `fetch_entry_t`.
  - Ports: push, pop, flush, count, head.
  - Pointers wrap modulo `FIFO_DEPTH`.
  - Flush has priority over push and pop.
- Top level holds the PC, inflight/kill logic, and the credit check.

## Test plan
- Reset release, SRAM model with mem[i] = 32'hA000_0000 + i, `i_ready`=1 → cycles 2,3,4 show `o_pc` 0,4,8 and `o_instr` A0000000, A0000001, A0000002.
- `i_ready`=0 for 10 cycles after the first valid → `o_imem_addr` stops advancing after 2 issues and `o_instr` is stable. Then `i_ready`=1 → PCs 0,4,8,12 are delivered once each, in order.
- Redirect to 32'h0000_0103 in cycle 5 → `o_pc`=32'h100 first appears in cycle 8, and no PC from the old stream appears in cycles 6–7.
- Redirect in the same cycle as a valid handshake, with a full FIFO → FIFO is flushed, the popped entry is not double-counted, and the next `o_pc` is the target.
- `RESET_PC`=32'hFFFF_FFF8 → PCs FFFFFFF8, FFFFFFFC, 00000000 are delivered in order.
- Assert `i_rst_n` low for 1 cycle mid-stream → `o_valid`=0 immediately. After release, `o_pc`=`RESET_PC` two cycles later. `o_imem_write`=0, `o_imem_read`=1 and `o_imem_size`=4'hF throughout.

Source files
------------

// File: rtl/ifetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ifetch_pkg
//  Description : Shared types and constants for the instruction fetch unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package ifetch_pkg;

   // One fetched instruction tagged with the address it was read from.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   // Active-low byte enables: all high means no byte is written.
   localparam logic [3:0]  IMEM_WEN_NONE = 4'hF;
   // Global write enable deasserted, so the SRAM performs a read every cycle.
   localparam logic        IMEM_READ     = 1'b1;
   // Sequential fetch advances one 32-bit word at a time.
   localparam logic [31:0] PC_STEP       = 32'd4;

endpackage : ifetch_pkg
`default_nettype wire

// File: rtl/ifetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : ifetch_fifo
//  Description : Small skid FIFO of {pc, instr} entries between the fetch
//                response path and decode. Flush overrides push and pop.
//  Revision    : 1.0 - initial release
// ============================================================================
module ifetch_fifo
   import ifetch_pkg::*;
#(
   parameter  int FIFO_DEPTH = 2,
   localparam int CNT_W      = $clog2(FIFO_DEPTH + 1),
   localparam int PTR_W      = $clog2(FIFO_DEPTH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               push,
   input  fetch_entry_t       push_data,
   input  logic               pop,
   input  logic               flush,
   output logic [CNT_W-1:0]   count,
   output fetch_entry_t       head
);

   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

   fetch_entry_t     mem [FIFO_DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] cnt;

   // Pointers wrap modulo the depth, which need not be a power of two.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   // Pointer and occupancy bookkeeping; flush empties the queue outright.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) wr_ptr <= next_ptr(wr_ptr);
         if (pop)  rd_ptr <= next_ptr(rd_ptr);
         if (push && !pop)      cnt <= cnt + CNT_W'(1);
         else if (!push && pop) cnt <= cnt - CNT_W'(1);
      end
   end

   // Storage needs no reset: the head is masked whenever the queue is empty.
   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= push_data;
   end

   assign count = cnt;
   // An occupied slot is never overwritten, so the head stays stable until popped.
   assign head  = (cnt != '0) ? mem[rd_ptr] : '0;

endmodule : ifetch_fifo
`default_nettype wire

// File: rtl/ifetch.sv
`default_nettype none
// ============================================================================
//  Module      : ifetch
//  Description : Instruction fetch unit. Issues sequential word reads to a
//                one-cycle-latency instruction SRAM, tags returned words with
//                their PC and queues them for decode; restarts on redirect.
//  Revision    : 1.0 - initial release
// ============================================================================
module ifetch
   import ifetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   output logic [31:0] o_imem_addr,
   input  logic [31:0] i_imem_rd_data,
   output logic [31:0] o_imem_wr_data,
   output logic [3:0]  o_imem_size,
   output logic        o_imem_write,
   output logic        o_imem_read,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   output logic        o_valid,
   input  logic        i_ready,
   output logic [31:0] o_instr,
   output logic [31:0] o_pc
);

   localparam int              CNT_W     = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W:0]  DEPTH_LIM = (CNT_W + 1)'(FIFO_DEPTH);

   logic [31:0]      fetch_pc;
   logic [31:0]      inflight_pc;
   logic             inflight;
   logic             kill;
   logic [CNT_W-1:0] count;
   logic [CNT_W:0]   credit_used;
   logic             pop;
   logic             push;
   logic             issue;
   fetch_entry_t     push_entry;
   fetch_entry_t     head;
   logic             unused_redirect_lsbs;

   // A redirect voids any handshake in the same cycle: the entry is flushed, not consumed.
   assign pop = o_valid & i_ready & ~i_redirect;

   // Slots already owed: queued entries plus the read in flight, minus the one leaving now.
   // Never negative because pop implies count >= 1.
   assign credit_used = {1'b0, count}
                      + {{CNT_W{1'b0}}, inflight}
                      - {{CNT_W{1'b0}}, pop};
   assign issue       = ~i_redirect & (credit_used < DEPTH_LIM);

   // A response is kept only if its read was issued after the last redirect.
   assign push       = inflight & ~kill;
   assign push_entry = '{pc: inflight_pc, instr: i_imem_rd_data};

   // Fetch PC, in-flight tracking and kill flag.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         fetch_pc    <= RESET_PC;
         inflight_pc <= '0;
         inflight    <= 1'b0;
         kill        <= 1'b0;
      end else begin
         kill     <= i_redirect;
         inflight <= issue;
         if (i_redirect) begin
            fetch_pc <= {i_redirect_pc[31:2], 2'b00};
         end else if (issue) begin
            inflight_pc <= fetch_pc;
            fetch_pc    <= fetch_pc + PC_STEP;
         end
      end
   end

   ifetch_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (i_clk),
      .rst_n     (i_rst_n),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .flush     (i_redirect),
      .count     (count),
      .head      (head)
   );

   // Redirect targets are forced word-aligned; the low bits carry no information.
   assign unused_redirect_lsbs = ^i_redirect_pc[1:0];

   assign o_imem_addr    = fetch_pc;
   assign o_imem_wr_data = 32'h0000_0000;
   assign o_imem_size    = IMEM_WEN_NONE;
   assign o_imem_write   = 1'b0;
   assign o_imem_read    = IMEM_READ;

   assign o_valid = (count != '0);
   assign o_instr = head.instr;
   assign o_pc    = head.pc;

endmodule : ifetch
`default_nettype wire
